ysyx_220053_ifu_prefetch: RTL and testbench

//  Parametrised instruction fetch unit with a prefetch queue. Replaces the blocking

---
 rtl/ysyx_220053_defs_pkg.sv | 15 +
 rtl/ysyx_220053_sync_fifo.sv | 64 ++++++
 rtl/ysyx_220053_ifu_prefetch.sv | 114 +++++++++++
 tb/tb_ysyx_220053_ifu_prefetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_defs_pkg.sv
// Shared definitions for the ysyx_220053 instruction fetch path:
// reset PC, instruction width and prefetch FSM state encoding.
package ysyx_220053_defs;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam int unsigned INSTR_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DROP
   } fetch_state_t;

endpackage

// File: rtl/ysyx_220053_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count and a flush that
// overrides any same-cycle push or pop.
module ysyx_220053_sync_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [PTR_W:0]   count_next;

   // A push into a full queue is only accepted when the head leaves in the same cycle.
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop)
         count_next = count + (PTR_W+1)'(1);
      else if (!do_push && do_pop)
         count_next = count - (PTR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         full  <= (count_next == (PTR_W+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ysyx_220053_ifu_prefetch.sv
// Instruction fetch unit: one outstanding aligned memory read at a time,
// 32-bit slot select, and a prefetch queue of {pc, instr} for decode.
module ysyx_220053_ifu_prefetch
   import ysyx_220053_defs::*;
#(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     MEM_W    = 64,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_220053_defs::RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redir_valid,
   input  logic [XLEN-1:0]    redir_pc,
   output logic               mreq_valid,
   input  logic               mreq_ready,
   output logic [XLEN-1:0]    mreq_addr,
   input  logic               mresp_valid,
   input  logic [MEM_W-1:0]   mresp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr
);

   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned ENTRY_W = XLEN + INSTR_W;

   fetch_state_t        state;
   fetch_state_t        state_next;
   logic [XLEN-1:0]     fetch_pc;
   logic [XLEN-1:0]     fetch_pc_next;
   logic                push;
   logic                flush;
   logic                full;
   logic                empty;
   logic [CNT_W-1:0]    count;
   logic [INSTR_W-1:0]  slot;
   logic [ENTRY_W-1:0]  head;
   logic                space_after_push;

   assign mreq_valid       = (state == REQ);
   assign mreq_addr        = fetch_pc & ~XLEN'(MEM_W/8 - 1);
   assign out_valid        = !empty;
   assign {out_pc, out_instr} = head;
   // Uses the count before any same-cycle pop.
   assign space_after_push = (count < CNT_W'(DEPTH - 1));

   generate
      if (MEM_W == 64) begin : g_slot64
         assign slot = fetch_pc[2] ? mresp_data[63:32] : mresp_data[31:0];
      end else begin : g_slot32
         assign slot = mresp_data[INSTR_W-1:0];
      end
   endgenerate

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      push          = 1'b0;
      flush         = 1'b0;
      if (redir_valid) begin
         flush         = 1'b1;
         fetch_pc_next = redir_pc & ~XLEN'(3);
         // A read still in flight after this edge must have its response discarded.
         if (((state == WAIT || state == DROP) && !mresp_valid) ||
             (state == REQ && mreq_ready))
            state_next = DROP;
         else
            state_next = REQ;
      end else begin
         unique case (state)
            IDLE: if (!full) state_next = REQ;
            REQ:  if (mreq_ready) state_next = WAIT;
            WAIT: begin
               if (mresp_valid) begin
                  push          = 1'b1;
                  fetch_pc_next = fetch_pc + XLEN'(4);
                  state_next    = space_after_push ? REQ : IDLE;
               end
            end
            DROP: if (mresp_valid) state_next = REQ;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
      end
   end

   ysyx_220053_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data ({fetch_pc, slot}),
      .pop       (out_ready),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

endmodule

// File: tb/tb_ysyx_220053_ifu_prefetch.sv
// Scoreboard bench for the prefetching fetch unit with a behavioural memory
// that answers each accepted read after a programmable latency.
module tb_ysyx_220053_ifu_prefetch;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned MEM_W  = 64;
   localparam int unsigned DEPTH  = 4;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redir_valid = 1'b0;
   logic [63:0] redir_pc = '0;
   logic        mreq_valid;
   logic        mreq_ready = 1'b1;
   logic [63:0] mreq_addr;
   logic        mresp_valid = 1'b0;
   logic [63:0] mresp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;

   ysyx_220053_ifu_prefetch #(
      .XLEN     (XLEN),
      .MEM_W    (MEM_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .mreq_valid  (mreq_valid),
      .mreq_ready  (mreq_ready),
      .mreq_addr   (mreq_addr),
      .mresp_valid (mresp_valid),
      .mresp_data  (mresp_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   int          errors = 0;
   int          checks = 0;
   entry_t      sb[$];
   logic [63:0] popped[$];
   logic [63:0] hs_addrs[$];
   logic [63:0] exp_pc = RST_PC;
   bit          pend = 0;
   bit          pend_stale = 0;
   logic [63:0] pend_addr = '0;
   int          dly = 0;
   int          lat = 1;
   bit          lat_rand = 0;
   bit          stall_rand = 0;
   bit          pop_rand = 0;
   bit          arm = 0;
   logic [63:0] arm_pc = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return a[31:0] ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [63:0] beat(input logic [63:0] a);
      logic [63:0] base;
      base = a & ~64'h7;
      return {word_at(base + 64'd4), word_at(base)};
   endfunction

   // Inputs for the coming edge are final here; outputs are stable at negedge.
   task automatic tick();
      bit     hs, resp, pop, rd;
      entry_t e;
      mresp_valid = 1'b0;
      mresp_data  = '0;
      if (!rst && pend) begin
         if (dly == 0) begin
            mresp_valid = 1'b1;
            mresp_data  = beat(pend_addr);
         end else begin
            dly--;
         end
      end
      mreq_ready = stall_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pop_rand) out_ready = ($urandom_range(0, 1) == 1);
      if (arm && mresp_valid) begin
         redir_valid = 1'b1;
         redir_pc    = arm_pc;
         arm         = 0;
      end
      hs   = mreq_valid && mreq_ready;
      resp = mresp_valid;
      pop  = out_valid && out_ready;
      rd   = redir_valid;
      if (rst) begin
         sb.delete();
         pend   = 0;
         exp_pc = RST_PC;
      end else begin
         if (pop && !rd) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               check("out_pc", out_pc, e.pc);
               check("out_instr", {32'b0, out_instr}, {32'b0, e.instr});
               popped.push_back(out_pc);
            end
         end
         if (hs) hs_addrs.push_back(mreq_addr);
         if (hs && !rd) check("mreq_addr", mreq_addr, exp_pc & ~64'h7);
         if (resp) begin
            if (!pend_stale && !rd) begin
               sb.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
               exp_pc = exp_pc + 64'd4;
            end
            pend = 0;
         end
         if (rd) begin
            sb.delete();
            exp_pc = redir_pc & ~64'h3;
            if (pend) pend_stale = 1;
         end
         if (hs) begin
            pend       = 1;
            pend_addr  = mreq_addr;
            pend_stale = rd;
            dly        = lat_rand ? $urandom_range(0, 2) : lat - 1;
         end
      end
      @(negedge clk);
      redir_valid = 1'b0;
   endtask

   initial begin
      int p0;
      int h0;
      @(negedge clk);

      // Reset and basic streaming
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_mreq_valid", {63'b0, mreq_valid}, 64'd0);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      out_ready = 1'b1;
      lat = 1;
      for (int i = 0; i < 60 && popped.size() < 3; i++) tick();
      check("t1_pops", popped.size(), 64'd3);
      if (popped.size() >= 3) begin
         check("t1_pc0", popped[0], 64'h8000_0000);
         check("t1_pc1", popped[1], 64'h8000_0004);
         check("t1_pc2", popped[2], 64'h8000_0008);
      end

      // Backpressure fills the queue exactly, then drains in order
      out_ready = 1'b0;
      repeat (20) tick();
      check("t2_queued", sb.size(), 64'd4);
      check("t2_mreq_valid_full", {63'b0, mreq_valid}, 64'd0);
      check("t2_out_valid_full", {63'b0, out_valid}, 64'd1);
      out_ready = 1'b1;
      p0 = popped.size();
      for (int i = 0; i < 80 && popped.size() < p0 + 6; i++) tick();
      check("t2_resumed", popped.size() >= p0 + 6, 64'd1);

      // Redirect while waiting for a response
      lat = 3;
      for (int i = 0; i < 40 && !(pend && dly >= 1); i++) tick();
      check("t3_in_wait", {63'b0, pend && dly >= 1}, 64'd1);
      redir_valid = 1'b1;
      redir_pc    = 64'h8000_1002;
      tick();
      h0 = hs_addrs.size();
      p0 = popped.size();
      for (int i = 0; i < 60 && popped.size() <= p0; i++) tick();
      check("t3_req_seen", hs_addrs.size() > h0, 64'd1);
      if (hs_addrs.size() > h0) check("t3_next_addr", hs_addrs[h0], 64'h8000_1000);
      check("t3_pop_seen", popped.size() > p0, 64'd1);
      if (popped.size() > p0) check("t3_next_pc", popped[p0], 64'h8000_1000);

      // Redirect coinciding with a response, three entries queued
      lat = 1;
      out_ready = 1'b0;
      for (int i = 0; i < 60 && sb.size() != 3; i++) tick();
      check("t4_three_queued", sb.size(), 64'd3);
      arm    = 1;
      arm_pc = 64'h8000_2000;
      for (int i = 0; i < 20 && arm; i++) tick();
      check("t4_redirected", {63'b0, arm}, 64'd0);
      check("t4_flushed", {63'b0, out_valid}, 64'd0);
      out_ready = 1'b1;
      p0 = popped.size();
      for (int i = 0; i < 60 && popped.size() <= p0; i++) tick();
      check("t4_pop_seen", popped.size() > p0, 64'd1);
      if (popped.size() > p0) check("t4_next_pc", popped[p0], 64'h8000_2000);

      // Random request stalls, decode stalls, latencies and redirects
      stall_rand = 1;
      pop_rand   = 1;
      lat_rand   = 1;
      p0 = popped.size();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 60) == 0) begin
            redir_valid = 1'b1;
            redir_pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_3FFF)};
         end
         tick();
      end
      check("t5_progress", popped.size() > p0 + 100, 64'd1);
      stall_rand = 0;
      pop_rand   = 0;
      lat_rand   = 0;

      // Reset in the middle of a wait
      lat = 3;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && !(pend && dly >= 1); i++) tick();
      check("t6_in_wait", {63'b0, pend && dly >= 1}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_out_valid", {63'b0, out_valid}, 64'd0);
      check("t6_mreq_valid", {63'b0, mreq_valid}, 64'd0);
      h0 = hs_addrs.size();
      for (int i = 0; i < 20 && hs_addrs.size() <= h0; i++) tick();
      check("t6_req_seen", hs_addrs.size() > h0, 64'd1);
      if (hs_addrs.size() > h0) check("t6_first_addr", hs_addrs[h0], 64'h8000_0000);
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
